// File: rtl/adder_pkg.sv
// Shared types for the adder result path: flag bit positions, flag struct and
// the result-stage FSM encoding.
package adder_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } res_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } adder_flags_t;

endpackage : adder_pkg

// File: rtl/adder_result_stage.sv
// Two-entry skid buffer registering adder sum/flags toward a valid/ready consumer.
// Optional STICKY_FLAGS_EN macro adds sticky carry/overflow tracking on pops.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_r,
    input  logic [FLAG_W-1:0] in_f,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_r,
    output logic [FLAG_W-1:0] out_f,
    output logic [1:0]        count
`ifdef STICKY_FLAGS_EN
    ,
    input  logic              sticky_clr,
    output logic              sticky_c,
    output logic              sticky_v
`endif
);

    res_state_t   state_q, state_d;
    logic [N-1:0] head_r_q, head_r_d;
    logic [N-1:0] tail_r_q, tail_r_d;
    adder_flags_t head_f_q, head_f_d;
    adder_flags_t tail_f_q, tail_f_d;
    logic [1:0]   count_q, count_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;

    logic push;
    logic pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Next-state, entry movement and registered status decode
    always_comb begin
        state_d  = state_q;
        head_r_d = head_r_q;
        head_f_d = head_f_q;
        tail_r_d = tail_r_q;
        tail_f_d = tail_f_q;

        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d  = ONE;
                    head_r_d = in_r;
                    head_f_d = adder_flags_t'(in_f);
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_r_d = in_r;
                    head_f_d = adder_flags_t'(in_f);
                end else if (push) begin
                    state_d  = FULL;
                    tail_r_d = in_r;
                    tail_f_d = adder_flags_t'(in_f);
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d  = ONE;
                    head_r_d = tail_r_q;
                    head_f_d = tail_f_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        count_d     = 2'd0;
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        case (state_d)
            ONE:     count_d = 2'd1;
            FULL:    count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_r_q    <= '0;
            head_f_q    <= '0;
            tail_r_q    <= '0;
            tail_f_q    <= '0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_r_q    <= head_r_d;
            head_f_q    <= head_f_d;
            tail_r_q    <= tail_r_d;
            tail_f_q    <= tail_f_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = head_r_q;
    assign out_f     = FLAG_W'(head_f_q);
    assign count     = count_q;

`ifdef STICKY_FLAGS_EN
    logic sticky_c_q, sticky_c_d;
    logic sticky_v_q, sticky_v_d;

    // Clear takes effect before the same cycle's popped flags are OR-ed in
    always_comb begin
        sticky_c_d = sticky_clr ? 1'b0 : sticky_c_q;
        sticky_v_d = sticky_clr ? 1'b0 : sticky_v_q;
        if (pop) begin
            sticky_c_d = sticky_c_d | out_f[FLAG_C];
            sticky_v_d = sticky_v_d | out_f[FLAG_V];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
        end else begin
            sticky_c_q <= sticky_c_d;
            sticky_v_q <= sticky_v_d;
        end
    end

    assign sticky_c = sticky_c_q;
    assign sticky_v = sticky_v_q;
`else
    // No sticky flag tracking in this build.
`endif

endmodule : adder_result_stage

// File: tb/tb_adder_result_stage.sv
// Directed self-checking bench for adder_result_stage (N=4).
// Exercises the sticky flag ports when STICKY_FLAGS_EN is defined.
module tb_adder_result_stage;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_r;
    logic [3:0]   in_f;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_r;
    logic [3:0]   out_f;
    logic [1:0]   count;
`ifdef STICKY_FLAGS_EN
    logic         sticky_clr;
    logic         sticky_c;
    logic         sticky_v;
`endif

    int checks_total;
    int checks_passed;

    adder_result_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_f      (in_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_f     (out_f),
        .count     (count)
`ifdef STICKY_FLAGS_EN
        ,
        .sticky_clr(sticky_clr),
        .sticky_c  (sticky_c),
        .sticky_v  (sticky_v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else checks_passed++;
        checks_total++;
        if (count !== 2'd0) $display("FAIL reset_count got %0d want 0", count);
        else checks_passed++;
        checks_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
        else checks_passed++;
        checks_total++;
        if (out_r !== 4'b0000 || out_f !== 4'b0000)
            $display("FAIL reset_out_data got %b/%b want 0000/0000", out_r, out_f);
        else checks_passed++;
        rst_n = 1'b1;
        step();
        checks_total++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready);
        else checks_passed++;
    endtask

    task automatic test_single_push();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_r      = 4'b1110;
        in_f      = 4'b1000;
        step();
        in_valid = 1'b0;
        checks_total++;
        if (out_valid !== 1'b1 || out_r !== 4'b1110 || out_f !== 4'b1000 || count !== 2'd1)
            $display("FAIL single_push got v=%b r=%b f=%b c=%0d want v=1 r=1110 f=1000 c=1",
                     out_valid, out_r, out_f, count);
        else checks_passed++;
        step();
        checks_total++;
        if (out_valid !== 1'b0 || count !== 2'd0)
            $display("FAIL single_pop got v=%b c=%0d want v=0 c=0", out_valid, count);
        else checks_passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_r      = 4'b0000;
        in_f      = 4'b0110;
        step();
        in_r = 4'b0010;
        in_f = 4'b0000;
        step();
        in_valid = 1'b0;
        checks_total++;
        if (count !== 2'd2 || in_ready !== 1'b0)
            $display("FAIL bp_full got c=%0d rdy=%b want c=2 rdy=0", count, in_ready);
        else checks_passed++;
        checks_total++;
        if (out_valid !== 1'b1 || out_r !== 4'b0000 || out_f !== 4'b0110)
            $display("FAIL bp_head got v=%b r=%b f=%b want v=1 r=0000 f=0110", out_valid, out_r, out_f);
        else checks_passed++;
        step();
        checks_total++;
        if (out_r !== 4'b0000 || out_f !== 4'b0110 || count !== 2'd2)
            $display("FAIL bp_hold got r=%b f=%b c=%0d want r=0000 f=0110 c=2", out_r, out_f, count);
        else checks_passed++;
        out_ready = 1'b1;
        step();
        checks_total++;
        if (count !== 2'd1 || out_r !== 4'b0010 || out_f !== 4'b0000 || in_ready !== 1'b1)
            $display("FAIL bp_pop1 got c=%0d r=%b f=%b rdy=%b want c=1 r=0010 f=0000 rdy=1",
                     count, out_r, out_f, in_ready);
        else checks_passed++;
        step();
        checks_total++;
        if (count !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL bp_pop2 got c=%0d v=%b want c=0 v=0", count, out_valid);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_r      = 4'b0101;
        in_f      = 4'b0001;
        step();
        checks_total++;
        if (count !== 2'd1 || out_r !== 4'b0101)
            $display("FAIL b2b_setup got c=%0d r=%b want c=1 r=0101", count, out_r);
        else checks_passed++;
        out_ready = 1'b1;
        in_r      = 4'b0011;
        in_f      = 4'b0000;
        step();
        in_valid = 1'b0;
        checks_total++;
        if (count !== 2'd1 || out_r !== 4'b0011 || out_f !== 4'b0000 || out_valid !== 1'b1)
            $display("FAIL b2b_replace got c=%0d r=%b f=%b v=%b want c=1 r=0011 f=0000 v=1",
                     count, out_r, out_f, out_valid);
        else checks_passed++;
        step();
        checks_total++;
        if (count !== 2'd0) $display("FAIL b2b_drain got c=%0d want 0", count);
        else checks_passed++;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_r      = 4'b1001;
        in_f      = 4'b1010;
        step();
        in_r = 4'b0111;
        in_f = 4'b0011;
        step();
        in_valid = 1'b0;
        checks_total++;
        if (count !== 2'd2) $display("FAIL mr_full got c=%0d want 2", count);
        else checks_passed++;
        rst_n = 1'b0;
        step();
        checks_total++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_r !== 4'b0000)
            $display("FAIL mr_cleared got c=%0d v=%b rdy=%b r=%b want c=0 v=0 rdy=0 r=0000",
                     count, out_valid, in_ready, out_r);
        else checks_passed++;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        checks_total++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mr_release got c=%0d v=%b rdy=%b want c=0 v=0 rdy=1", count, out_valid, in_ready);
        else checks_passed++;
    endtask

`ifdef STICKY_FLAGS_EN
    task automatic test_sticky();
        out_ready  = 1'b1;
        sticky_clr = 1'b0;
        in_valid   = 1'b1;
        in_r       = 4'b0100;
        in_f       = 4'b0110;
        step();
        in_valid = 1'b0;
        step();
        checks_total++;
        if (sticky_c !== 1'b1 || sticky_v !== 1'b0)
            $display("FAIL sticky_set got c=%b v=%b want c=1 v=0", sticky_c, sticky_v);
        else checks_passed++;
        in_valid = 1'b1;
        in_r     = 4'b0001;
        in_f     = 4'b0001;
        step();
        in_valid   = 1'b0;
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks_total++;
        if (sticky_c !== 1'b0 || sticky_v !== 1'b1)
            $display("FAIL sticky_clr_pop got c=%b v=%b want c=0 v=1", sticky_c, sticky_v);
        else checks_passed++;
    endtask
`endif

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_r      = '0;
        in_f      = '0;
        out_ready = 1'b1;
`ifdef STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        #2;
        test_reset();
        test_single_push();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_adder_result_stage
